pipeline_flow_control: RTL

//  Sequential successor to the combinational pipeline controller: owns PC-write, stall, bubble and

---
 rtl/pipeline_flow_control_pkg.sv | 27 ++
 rtl/pipeline_flow_control_if.sv | 25 ++
 rtl/pipeline_flow_control_sat_counter.sv | 21 ++
 rtl/pipeline_flow_control.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipeline_flow_control_pkg.sv
// Shared types and constants for the pipeline flow controller: opcodes, PC-select codes and FSM states.
package pipeline_flow_control_pkg;

   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

   localparam logic [1:0] CTL_PC_PC4     = 2'd0;
   localparam logic [1:0] CTL_PC_PC_IMM  = 2'd1;
   localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;
   localparam logic [1:0] CTL_PC_PC4_BR  = 2'd3;

   // Wide enough for BRANCH_LATENCY-2 with BRANCH_LATENCY up to 15
   localparam int LAT_CNT_W = 4;

   typedef enum logic [1:0] {RUN, WAIT, REDIRECT} flow_state_t;

   function automatic logic is_control_op(input logic valid, input logic [6:0] opcode);
      return valid && (opcode == OPCODE_BRANCH || opcode == OPCODE_JAL || opcode == OPCODE_JALR);
   endfunction

endpackage

// File: rtl/pipeline_flow_control_if.sv
// Decode/fetch handshake bundle seen by the flow controller; decode is master, controller is slave.
interface pipeline_flow_control_if;
   logic       inst_valid;
   logic [6:0] inst_opcode;
   logic       take_branch;
   logic       want_stall;
   logic       pc_write_enable;
   logic       no_stall;
   logic       jump_start;
   logic       inject_bubble;
   logic [1:0] next_pc_select;
   logic       redirect_regfile_we;

   modport master (
      output inst_valid, inst_opcode, take_branch, want_stall,
      input  pc_write_enable, no_stall, jump_start, inject_bubble, next_pc_select,
             redirect_regfile_we
   );

   modport slave (
      input  inst_valid, inst_opcode, take_branch, want_stall,
      output pc_write_enable, no_stall, jump_start, inject_bubble, next_pc_select,
             redirect_regfile_we
   );
endinterface

// File: rtl/pipeline_flow_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_flow_control.sv
// PC-write / stall / bubble / redirect sequencer with a fixed branch-resolution latency.
// Define PIPELINE_PREDICT_NT_EN to predict BRANCH not-taken and flush only when it resolves taken.
//
// state    | meaning
// RUN      | normal fetch; accepts stalls and new control transfers
// WAIT     | counting down branch-resolution latency
// REDIRECT | one cycle issuing the resolved next-PC select
module pipeline_flow_control
   import pipeline_flow_control_pkg::*;
#(
   parameter int BRANCH_LATENCY = 2,
   parameter int STALL_CNT_W    = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   pipeline_flow_control_if.slave bus,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   flow_state_t          state, state_nxt;
   logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
   logic [6:0]           held_op, held_op_nxt;
   logic                 pc_we, no_stall, jump_start, bubble, rf_we;
   logic [1:0]           pc_sel;
   logic                 ctl_now;

   assign ctl_now = is_control_op(bus.inst_valid, bus.inst_opcode);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         cnt     <= '0;
         held_op <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         held_op <= held_op_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      held_op_nxt = held_op;
      pc_we       = 1'b1;
      no_stall    = 1'b1;
      jump_start  = 1'b0;
      bubble      = 1'b0;
      pc_sel      = CTL_PC_PC4;
      rf_we       = 1'b0;
      case (state)
         RUN: begin
            if (bus.want_stall) begin
               pc_we    = 1'b0;
               no_stall = 1'b0;
               bubble   = 1'b1;
            end else if (ctl_now) begin
               jump_start  = 1'b1;
               held_op_nxt = bus.inst_opcode;
`ifdef PIPELINE_PREDICT_NT_EN
               if (bus.inst_opcode != OPCODE_BRANCH) begin
                  pc_we    = 1'b0;
                  no_stall = 1'b0;
               end
`else
               pc_we    = 1'b0;
               no_stall = 1'b0;
`endif
               if (BRANCH_LATENCY == 1) begin
                  state_nxt = REDIRECT;
               end else begin
                  cnt_nxt   = LAT_CNT_W'(BRANCH_LATENCY - 2);
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
`ifdef PIPELINE_PREDICT_NT_EN
            // Predicted branch keeps fetching; only a second control op is held back
            if (held_op != OPCODE_BRANCH || ctl_now) begin
               pc_we    = 1'b0;
               no_stall = 1'b0;
               bubble   = 1'b1;
            end
`else
            pc_we    = 1'b0;
            no_stall = 1'b0;
            bubble   = 1'b1;
`endif
            if (cnt == '0)
               state_nxt = REDIRECT;
            else
               cnt_nxt = cnt - 1'b1;
         end
         REDIRECT: begin
            state_nxt = RUN;
            case (held_op)
               OPCODE_BRANCH: begin
`ifdef PIPELINE_PREDICT_NT_EN
                  if (bus.take_branch) begin
                     pc_sel = CTL_PC_PC_IMM;
                     bubble = 1'b1;
                  end else if (ctl_now) begin
                     pc_we    = 1'b0;
                     no_stall = 1'b0;
                     bubble   = 1'b1;
                  end
`else
                  pc_sel = bus.take_branch ? CTL_PC_PC_IMM : CTL_PC_PC4_BR;
`endif
               end
               OPCODE_JAL: begin
                  pc_sel = CTL_PC_PC_IMM;
                  rf_we  = 1'b1;
               end
               OPCODE_JALR: begin
                  pc_sel = CTL_PC_RS1_IMM;
                  rf_we  = 1'b1;
               end
               default: pc_sel = CTL_PC_PC4;
            endcase
         end
         default: state_nxt = RUN;
      endcase
      // Present the documented reset values regardless of what decode drives
      if (reset) begin
         pc_we      = 1'b1;
         no_stall   = 1'b1;
         jump_start = 1'b0;
         bubble     = 1'b0;
         pc_sel     = CTL_PC_PC4;
         rf_we      = 1'b0;
      end
   end

   assign bus.pc_write_enable     = pc_we;
   assign bus.no_stall            = no_stall;
   assign bus.jump_start          = jump_start;
   assign bus.inject_bubble       = bubble;
   assign bus.next_pc_select      = pc_sel;
   assign bus.redirect_regfile_we = rf_we;

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (~no_stall),
      .clear  (1'b0),
      .count  (stall_cycles)
   );

endmodule
